cursor_overlay: RTL and testbench
=================================

Name: cursor_overlay

Overview:
- Parametrised, frame-synchronous cursor overlay stage in the VGA timing chain; supersedes the fixed-size mouse overlay.
- Takes the timing bus (hcount/vcount/sync/blank) plus RGB, and a cursor position with a valid strobe.
- Draws one of three cursor shapes in a configurable colour pair.
- Position and mode are applied only at frame boundaries, so the cursor never tears.
- Every output is delayed by a fixed 2-cycle pipeline.

Parameters:
CUR_W, 16, cursor bitmap/box width in pixels (power of 2, 4..64)
CUR_H, 16, cursor bitmap/box height in pixels (power of 2, 4..64)
CNT_BITS, 11, width of hcount/vcount
POS_BITS, 12, width of xpos/ypos
RGB_BITS, 12, pixel colour width (3 equal channels)
FILL_COLOR, 12'hFFF, colour for fill pixels
EDGE_COLOR, 12'h000, colour for outline pixels

Ports:
pclk  in  1  pixel clock, all logic on rising edge
rst_lck  in  1  synchronous active-high reset
xpos  in  POS_BITS  cursor hot-spot X (top-left of bitmap)
ypos  in  POS_BITS  cursor hot-spot Y
pos_valid  in  1  one-cycle strobe; captures xpos/ypos/mode into shadow registers
mode  in  2  0 off, 1 arrow bitmap, 2 crosshair, 3 box outline
hcount_in  in  CNT_BITS  horizontal counter
hsync_in  in  1  horizontal sync
hblnk_in  in  1  horizontal blank
vcount_in  in  CNT_BITS  vertical counter
vsync_in  in  1  vertical sync
vblnk_in  in  1  vertical blank
rgb_in  in  RGB_BITS  background pixel
hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out  out  as inputs  timing delayed by 2 cycles
rgb_out  out  RGB_BITS  composited pixel, registered, aligned with the timing outputs

Behaviour:
- Reset (sync, rst_lck=1 at a pclk edge): all outputs 0. Shadow and active xpos/ypos are 0, mode is 0 (off), and the pipeline is cleared.
- Reset mid-frame: the outputs show 0 for 2 cycles after release, then pass-through resumes with the cursor off until a pos_valid strobe and the next frame boundary.
- Shadow capture: on pos_valid=1, shadow_{x,y,mode} <= {xpos,ypos,mode}. Strobes between frame boundaries overwrite each other; the last one wins.
- Frame boundary: the rising edge of vblnk_in (registered compare of vblnk_in against its previous value). On that cycle, active <= shadow.
  - If pos_valid coincides with the frame-boundary cycle, active takes the incoming xpos/ypos/mode directly, so the latest value is never lost.
- Stage 1 (registered):
  - dx = hcount_in - active_x, dy = vcount_in - active_y, computed signed at POS_BITS+1 with no wrap.
  - in_box = (0 <= dx < CUR_W) && (0 <= dy < CUR_H).
  - on_cross = (hcount_in == active_x) || (vcount_in == active_y).
  - on_edge = in_box && (dx==0 || dx==CUR_W-1 || dy==0 || dy==CUR_H-1).
  - blank = hblnk_in || vblnk_in.
  - Timing signals and rgb_in are also registered.
- Stage 2 (registered): the ROM returns a 2-bit code for (dx[log2 CUR_W-1:0], dy[log2 CUR_H-1:0]).
  - Code meanings: 00 transparent, 01 fill, 10 edge, 11 treated as transparent.
  - The ROM is combinational and indexed from the stage-1 registers.
- Output rgb_out, in priority order:
  - blank → 0.
  - mode 0 → rgb.
  - mode 1 → FILL_COLOR or EDGE_COLOR when in_box and the code is non-transparent, otherwise rgb.
  - mode 2 → FILL_COLOR when on_cross, otherwise rgb.
  - mode 3 → FILL_COLOR when on_edge, otherwise rgb.
- Clipping: a cursor partially off-screen (xpos > last visible column, or at any position ≤ 4095) is drawn only where the counters reach. There is no wrap to the left or top edge. Positions beyond the counter range draw nothing.
- Latency: exactly 2 pclk cycles for every output, in every mode.

Decomposition:
- Shared package (vga_pkg): mode encodings (MODE_OFF/ARROW/CROSS/BOX), ROM pixel codes (PIX_CLR/FILL/EDGE), and the default timing widths.
- One sub-module, cursor_rom: a combinational case/ROM parametrised on CUR_W/CUR_H that returns the 2-bit code.
  - It scales a 16x16 arrow pattern by index truncation or replication.

Test Plan:
- Reset: hold rst_lck 3 cycles with random inputs → all outputs 0. After release, timing_out equals timing_in delayed 2 cycles and rgb_out equals rgb_in delayed 2 cycles (mode off).
- Frame sync: pos_valid with x=100,y=50,mode=3 mid-frame → no change in the current frame. After the vblnk rising edge, the next frame shows the FILL_COLOR box outline at columns 100/115 and rows 50/65.
- Coincident strobe: pos_valid (x=200,y=200,mode=2) on the exact vblnk rising-edge cycle → the next frame draws the crosshair at column 200 and row 200 across the full active area.
- Arrow bitmap: mode=1, x=0,y=0 → the pixel at (0,0) is EDGE_COLOR and the interior ROM fill pixels are FILL_COLOR. Pixels at dx ≥ 16 equal rgb_in.
- Clipping: mode=3, x=1020,y=760 on 1024x768 → only columns 1020..1023 and rows 760..767 are modified. Column 0 of the following lines is unmodified (no wrap).
- Blanking: cursor overlapping the hblnk region → rgb_out=0 whenever the delayed blank is high, regardless of mode.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA overlay stages: cursor mode encodings,
// cursor ROM pixel codes and the default timing-bus widths.
package vga_pkg;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_ARROW = 2'd1,
      MODE_CROSS = 2'd2,
      MODE_BOX   = 2'd3
   } cursor_mode_t;

   typedef enum logic [1:0] {
      PIX_CLR  = 2'd0,
      PIX_FILL = 2'd1,
      PIX_EDGE = 2'd2,
      PIX_RSVD = 2'd3   // reserved, drawn as transparent
   } pix_code_t;

   localparam int CNT_BITS_DEF = 11;
   localparam int POS_BITS_DEF = 12;
   localparam int RGB_BITS_DEF = 12;

   // Native resolution of the arrow artwork; other cursor sizes are scaled.
   localparam int ARROW_SIZE = 16;

endpackage

// File: rtl/cursor_rom.sv
// Combinational arrow-cursor ROM. The artwork is a 16x16 arrow (triangular
// head plus a 3-pixel-wide stem); other CUR_W/CUR_H sizes map onto it by
// index truncation (smaller) or pixel replication (larger).
module cursor_rom
   import vga_pkg::*;
#(
   parameter int CUR_W = 16,
   parameter int CUR_H = 16,
   localparam int XB = $clog2(CUR_W),
   localparam int YB = $clog2(CUR_H)
) (
   input  logic [XB-1:0] dx,
   input  logic [YB-1:0] dy,
   output logic [1:0]    code
);

   logic [3:0] sx;
   logic [3:0] sy;

   // Map cursor-space indices onto the 16x16 artwork: (d * 16) / size.
   assign sx = 4'({dx, 4'b0000} >> XB);
   assign sy = 4'({dy, 4'b0000} >> YB);

   // Arrow shape: rows 0..11 are a right triangle outlined by column 0 and
   // the diagonal; rows 12..14 are a stem at columns 3..5; row 15 caps it.
   always_comb begin
      code = PIX_CLR;
      if (sy <= 4'd11) begin
         if (sx == 4'd0 || sx == sy) begin
            code = PIX_EDGE;
         end else if (sx < sy) begin
            code = PIX_FILL;
         end
      end else if (sy == 4'd15) begin
         if (sx >= 4'd3 && sx <= 4'd5) begin
            code = PIX_EDGE;
         end
      end else begin
         if (sx == 4'd3 || sx == 4'd5) begin
            code = PIX_EDGE;
         end else if (sx == 4'd4) begin
            code = PIX_FILL;
         end
      end
   end

endmodule

// File: rtl/cursor_overlay.sv
// Frame-synchronous cursor overlay on the VGA timing bus. A new cursor
// position/mode is captured into shadow registers on pos_valid and only
// becomes active on the rising edge of vblnk_in, so a frame never tears.
// Every output (timing and pixel) is delayed by exactly two pclk cycles.
//
// pos_valid is a one-cycle strobe with no back-pressure: the block accepts
// xpos/ypos/mode on every cycle pos_valid is high, the last strobe before a
// frame boundary wins, and a strobe on the boundary cycle itself is applied
// directly to the new frame.
module cursor_overlay
   import vga_pkg::*;
#(
   parameter int CUR_W    = 16,
   parameter int CUR_H    = 16,
   parameter int CNT_BITS = CNT_BITS_DEF,
   parameter int POS_BITS = POS_BITS_DEF,
   parameter int RGB_BITS = RGB_BITS_DEF,
   parameter logic [RGB_BITS-1:0] FILL_COLOR = 12'hFFF,
   parameter logic [RGB_BITS-1:0] EDGE_COLOR = 12'h000
) (
   input  logic                pclk,
   input  logic                rst_lck,
   input  logic [POS_BITS-1:0] xpos,
   input  logic [POS_BITS-1:0] ypos,
   input  logic                pos_valid,
   input  logic [1:0]          mode,
   input  logic [CNT_BITS-1:0] hcount_in,
   input  logic                hsync_in,
   input  logic                hblnk_in,
   input  logic [CNT_BITS-1:0] vcount_in,
   input  logic                vsync_in,
   input  logic                vblnk_in,
   input  logic [RGB_BITS-1:0] rgb_in,
   output logic [CNT_BITS-1:0] hcount_out,
   output logic                hsync_out,
   output logic                hblnk_out,
   output logic [CNT_BITS-1:0] vcount_out,
   output logic                vsync_out,
   output logic                vblnk_out,
   output logic [RGB_BITS-1:0] rgb_out
);

   localparam int XB = $clog2(CUR_W);
   localparam int YB = $clog2(CUR_H);
   // One extra bit so counter - position never wraps (counters are narrower).
   localparam int DW = POS_BITS + 1;

   localparam logic signed [DW-1:0] ZERO_S = '0;
   localparam logic signed [DW-1:0] W_S    = DW'(CUR_W);
   localparam logic signed [DW-1:0] W_LAST = DW'(CUR_W - 1);
   localparam logic signed [DW-1:0] H_S    = DW'(CUR_H);
   localparam logic signed [DW-1:0] H_LAST = DW'(CUR_H - 1);

   // Shadow (pending) and active (this frame) cursor state.
   logic [POS_BITS-1:0] shd_x, shd_y, act_x, act_y;
   cursor_mode_t        shd_mode, act_mode;
   logic                vblnk_prev;
   logic                frame_start;

   assign frame_start = vblnk_in & ~vblnk_prev;

   // Capture strobes into the shadow and promote them at each frame boundary.
   always_ff @(posedge pclk) begin
      if (rst_lck) begin
         shd_x      <= '0;
         shd_y      <= '0;
         shd_mode   <= MODE_OFF;
         act_x      <= '0;
         act_y      <= '0;
         act_mode   <= MODE_OFF;
         vblnk_prev <= 1'b0;
      end else begin
         vblnk_prev <= vblnk_in;
         if (pos_valid) begin
            shd_x    <= xpos;
            shd_y    <= ypos;
            shd_mode <= cursor_mode_t'(mode);
         end
         if (frame_start) begin
            if (pos_valid) begin
               act_x    <= xpos;
               act_y    <= ypos;
               act_mode <= cursor_mode_t'(mode);
            end else begin
               act_x    <= shd_x;
               act_y    <= shd_y;
               act_mode <= shd_mode;
            end
         end
      end
   end

   // Stage-1 geometry: signed offsets of the beam from the hot spot.
   logic [DW-1:0]        h_ext, v_ext, ax_ext, ay_ext;
   logic signed [DW-1:0] dx_c, dy_c;
   logic                 in_box_c, on_edge_c, on_cross_c;

   assign h_ext      = DW'(hcount_in);
   assign v_ext      = DW'(vcount_in);
   assign ax_ext     = DW'(act_x);
   assign ay_ext     = DW'(act_y);
   assign dx_c       = $signed(h_ext - ax_ext);
   assign dy_c       = $signed(v_ext - ay_ext);
   assign in_box_c   = !dx_c[DW-1] && (dx_c < W_S) && !dy_c[DW-1] && (dy_c < H_S);
   assign on_edge_c  = in_box_c && (dx_c == ZERO_S || dx_c == W_LAST ||
                                    dy_c == ZERO_S || dy_c == H_LAST);
   assign on_cross_c = (h_ext == ax_ext) || (v_ext == ay_ext);

   logic [XB-1:0]       s1_dx;
   logic [YB-1:0]       s1_dy;
   logic                s1_in_box, s1_on_edge, s1_on_cross, s1_blank;
   cursor_mode_t        s1_mode;
   logic [CNT_BITS-1:0] s1_hcount, s1_vcount;
   logic                s1_hsync, s1_hblnk, s1_vsync, s1_vblnk;
   logic [RGB_BITS-1:0] s1_rgb;

   // Stage 1: register geometry flags, ROM index, mode, timing and background.
   always_ff @(posedge pclk) begin
      if (rst_lck) begin
         s1_dx       <= '0;
         s1_dy       <= '0;
         s1_in_box   <= 1'b0;
         s1_on_edge  <= 1'b0;
         s1_on_cross <= 1'b0;
         s1_blank    <= 1'b0;
         s1_mode     <= MODE_OFF;
         s1_hcount   <= '0;
         s1_hsync    <= 1'b0;
         s1_hblnk    <= 1'b0;
         s1_vcount   <= '0;
         s1_vsync    <= 1'b0;
         s1_vblnk    <= 1'b0;
         s1_rgb      <= '0;
      end else begin
         s1_dx       <= dx_c[XB-1:0];
         s1_dy       <= dy_c[YB-1:0];
         s1_in_box   <= in_box_c;
         s1_on_edge  <= on_edge_c;
         s1_on_cross <= on_cross_c;
         s1_blank    <= hblnk_in | vblnk_in;
         s1_mode     <= act_mode;
         s1_hcount   <= hcount_in;
         s1_hsync    <= hsync_in;
         s1_hblnk    <= hblnk_in;
         s1_vcount   <= vcount_in;
         s1_vsync    <= vsync_in;
         s1_vblnk    <= vblnk_in;
         s1_rgb      <= rgb_in;
      end
   end

   logic [1:0] rom_code;

   cursor_rom #(
      .CUR_W (CUR_W),
      .CUR_H (CUR_H)
   ) u_rom (
      .dx   (s1_dx),
      .dy   (s1_dy),
      .code (rom_code)
   );

   logic [RGB_BITS-1:0] pix_c;

   // Compositing priority: blank, then the selected cursor shape, else background.
   always_comb begin
      pix_c = s1_rgb;
      if (s1_blank) begin
         pix_c = '0;
      end else begin
         case (s1_mode)
            MODE_ARROW: begin
               if (s1_in_box && rom_code == PIX_FILL) begin
                  pix_c = FILL_COLOR;
               end else if (s1_in_box && rom_code == PIX_EDGE) begin
                  pix_c = EDGE_COLOR;
               end
            end
            MODE_CROSS: begin
               if (s1_on_cross) begin
                  pix_c = FILL_COLOR;
               end
            end
            MODE_BOX: begin
               if (s1_on_edge) begin
                  pix_c = FILL_COLOR;
               end
            end
            default: pix_c = s1_rgb;
         endcase
      end
   end

   // Stage 2: register the composited pixel alongside the delayed timing.
   always_ff @(posedge pclk) begin
      if (rst_lck) begin
         hcount_out <= '0;
         hsync_out  <= 1'b0;
         hblnk_out  <= 1'b0;
         vcount_out <= '0;
         vsync_out  <= 1'b0;
         vblnk_out  <= 1'b0;
         rgb_out    <= '0;
      end else begin
         hcount_out <= s1_hcount;
         hsync_out  <= s1_hsync;
         hblnk_out  <= s1_hblnk;
         vcount_out <= s1_vcount;
         vsync_out  <= s1_vsync;
         vblnk_out  <= s1_vblnk;
         rgb_out    <= pix_c;
      end
   end

endmodule

// File: tb/tb_cursor_overlay.sv
// Self-checking bench for cursor_overlay: randomised pixel streams on a
// 1024x768 timing layout, compared against a behavioural model of the
// cursor rules with an expected queue covering the 2-cycle latency.
module tb_cursor_overlay;

   localparam int CUR_W    = 16;
   localparam int CUR_H    = 16;
   localparam int CNT_BITS = 11;
   localparam int POS_BITS = 12;
   localparam int RGB_BITS = 12;
   localparam logic [RGB_BITS-1:0] FILL = 12'hFFF;
   localparam logic [RGB_BITS-1:0] EDGE = 12'h000;
   localparam int H_VIS = 1024;
   localparam int V_VIS = 768;
   localparam int H_TOT = 1344;
   localparam int V_TOT = 806;
   localparam int EXP_W = 2 * CNT_BITS + 4 + RGB_BITS;

   // ---------------- clock / reset / DUT ----------------
   logic                pclk = 1'b0;
   logic                rst_lck;
   logic [POS_BITS-1:0] xpos, ypos;
   logic                pos_valid;
   logic [1:0]          mode;
   logic [CNT_BITS-1:0] hcount_in, vcount_in, hcount_out, vcount_out;
   logic                hsync_in, hblnk_in, vsync_in, vblnk_in;
   logic                hsync_out, hblnk_out, vsync_out, vblnk_out;
   logic [RGB_BITS-1:0] rgb_in, rgb_out;

   always #5 pclk = ~pclk;

   cursor_overlay #(
      .CUR_W(CUR_W), .CUR_H(CUR_H), .CNT_BITS(CNT_BITS), .POS_BITS(POS_BITS),
      .RGB_BITS(RGB_BITS), .FILL_COLOR(FILL), .EDGE_COLOR(EDGE)
   ) dut (
      .pclk(pclk), .rst_lck(rst_lck), .xpos(xpos), .ypos(ypos),
      .pos_valid(pos_valid), .mode(mode),
      .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
      .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
      .rgb_in(rgb_in),
      .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
      .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
      .rgb_out(rgb_out)
   );

   // ---------------- scoreboard state ----------------
   logic [EXP_W-1:0] exp_q[$];
   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      bit rst;
      int h;
      int v;
      bit pv;
      int x;
      int y;
      int m;
   } stim_t;

   // Arrow artwork as seen on screen: E = outline, F = fill, . = transparent.
   string arrow_pic [16] = '{
      "E...............",
      "EE..............",
      "EFE.............",
      "EFFE............",
      "EFFFE...........",
      "EFFFFE..........",
      "EFFFFFE.........",
      "EFFFFFFE........",
      "EFFFFFFFE.......",
      "EFFFFFFFFE......",
      "EFFFFFFFFFE.....",
      "EFFFFFFFFFFE....",
      "...EFE..........",
      "...EFE..........",
      "...EFE..........",
      "...EEE.........."
   };

   // Reference cursor state: pending (shadow) and on-screen (active).
   int sh_x = 0, sh_y = 0, sh_m = 0;
   int ac_x = 0, ac_y = 0, ac_m = 0;
   bit prev_vb = 0;

   function automatic stim_t mk(int h, int v, bit pv = 0, int x = 0, int y = 0,
                                int m = 0, bit rst = 0);
      stim_t s;
      s.rst = rst; s.h = h; s.v = v; s.pv = pv; s.x = x; s.y = y; s.m = m;
      return s;
   endfunction

   // What the screen should show at (h, v) with background bg.
   function automatic logic [RGB_BITS-1:0] model_pixel(int h, int v, bit blank,
                                                       logic [RGB_BITS-1:0] bg);
      int dx, dy;
      bit in_box;
      byte ch;
      string row;
      if (blank) return '0;
      dx = h - ac_x;
      dy = v - ac_y;
      in_box = (dx >= 0) && (dx < CUR_W) && (dy >= 0) && (dy < CUR_H);
      case (ac_m)
         1: begin
            if (!in_box) return bg;
            row = arrow_pic[(dy * 16) / CUR_H];
            ch  = row[(dx * 16) / CUR_W];
            if (ch == "E") return EDGE;
            if (ch == "F") return FILL;
            return bg;
         end
         2: return (h == ac_x || v == ac_y) ? FILL : bg;
         3: return (in_box && (dx == 0 || dx == CUR_W - 1 || dy == 0 || dy == CUR_H - 1))
                   ? FILL : bg;
         default: return bg;
      endcase
   endfunction

   // ---------------- driver ----------------
   // One pixel per call: samples the outputs, pops the expectation for the
   // pixel driven two cycles earlier, then drives the next pixel.
   task automatic drive_cycle(input stim_t s, output bit have_exp,
                              output logic [EXP_W-1:0] got,
                              output logic [EXP_W-1:0] expv);
      bit hb, vb, hs, vs, fb;
      logic [RGB_BITS-1:0] bg;
      @(negedge pclk);
      got = {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out, rgb_out};
      have_exp = 0;
      expv = '0;
      if (exp_q.size() >= 2) begin
         expv = exp_q.pop_front();
         have_exp = 1;
      end
      hb = (s.h >= H_VIS);
      vb = (s.v >= V_VIS);
      hs = (s.h >= 1048 && s.h < 1184);
      vs = (s.v >= 771 && s.v < 777);
      bg = RGB_BITS'($urandom);
      rst_lck   = s.rst;
      hcount_in = CNT_BITS'(s.h);
      vcount_in = CNT_BITS'(s.v);
      hblnk_in  = hb;
      vblnk_in  = vb;
      hsync_in  = hs;
      vsync_in  = vs;
      rgb_in    = bg;
      pos_valid = s.pv;
      // Position/mode lines carry junk when not strobed.
      xpos = s.pv ? POS_BITS'(s.x) : POS_BITS'($urandom);
      ypos = s.pv ? POS_BITS'(s.y) : POS_BITS'($urandom);
      mode = s.pv ? 2'(s.m) : 2'($urandom);
      if (s.rst) begin
         foreach (exp_q[i]) exp_q[i] = '0;
         exp_q.push_back('0);
         sh_x = 0; sh_y = 0; sh_m = 0;
         ac_x = 0; ac_y = 0; ac_m = 0;
         prev_vb = 0;
      end else begin
         exp_q.push_back({CNT_BITS'(s.h), hs, hb, CNT_BITS'(s.v), vs, vb,
                          model_pixel(s.h, s.v, hb | vb, bg)});
         fb = vb && !prev_vb;
         prev_vb = vb;
         if (s.pv) begin
            sh_x = s.x; sh_y = s.y; sh_m = s.m;
         end
         if (fb) begin
            ac_x = sh_x; ac_y = sh_y; ac_m = sh_m;
         end
      end
   endtask

   function automatic int rnd(int lo, int hi);
      return int'($urandom_range(hi, lo));
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      stim_t items[$];
      bit have;
      logic [EXP_W-1:0] got, expv;
      for (int i = 0; i < 3; i++)
         items.push_back(mk(rnd(0, H_TOT - 1), rnd(0, V_TOT - 1), 1, 300, 300, 3, 1));
      for (int i = 0; i < 12; i++)
         items.push_back(mk(rnd(0, H_TOT - 1), rnd(0, V_VIS - 1)));
      foreach (items[i]) begin
         drive_cycle(items[i], have, got, expv);
         if (have) begin
            n_cmp++;
            if (got !== expv) begin
               n_fail++;
               $display("FAIL reset: got %h expected %h", got, expv);
            end
         end
      end
   endtask

   task automatic test_frame_sync();
      stim_t items[$];
      bit have;
      logic [EXP_W-1:0] got, expv;
      int rows[5] = '{49, 50, 57, 65, 66};
      items.push_back(mk(400, 300));
      items.push_back(mk(401, 300, 1, 100, 50, 3));
      // Same frame: box not yet active.
      for (int h = 97; h <= 118; h++) items.push_back(mk(h, 50));
      for (int h = 97; h <= 118; h++) items.push_back(mk(h, 65));
      items.push_back(mk(0, 767));
      items.push_back(mk(0, 768));
      items.push_back(mk(1, 769));
      foreach (rows[r])
         for (int h = 97; h <= 118; h++) items.push_back(mk(h, rows[r]));
      foreach (items[i]) begin
         drive_cycle(items[i], have, got, expv);
         if (have) begin
            n_cmp++;
            if (got !== expv) begin
               n_fail++;
               $display("FAIL frame_sync: got %h expected %h", got, expv);
            end
         end
      end
   endtask

   task automatic test_coincident();
      stim_t items[$];
      bit have;
      logic [EXP_W-1:0] got, expv;
      int cols[5] = '{0, 199, 200, 201, 1023};
      // Back-to-back strobes: only the one on the boundary cycle should show.
      items.push_back(mk(10, 400, 1, 10, 10, 1));
      items.push_back(mk(11, 400, 1, 500, 500, 3));
      items.push_back(mk(5, 767));
      items.push_back(mk(5, 768, 1, 200, 200, 2));
      items.push_back(mk(6, 768));
      for (int r = 199; r <= 201; r++) begin
         foreach (cols[c]) items.push_back(mk(cols[c], r));
         for (int k = 0; k < 6; k++) items.push_back(mk(rnd(0, H_VIS - 1), r));
      end
      for (int k = 0; k < 12; k++) items.push_back(mk(200, rnd(0, V_VIS - 1)));
      items.push_back(mk(10, 10));
      items.push_back(mk(500, 500));
      foreach (items[i]) begin
         drive_cycle(items[i], have, got, expv);
         if (have) begin
            n_cmp++;
            if (got !== expv) begin
               n_fail++;
               $display("FAIL coincident: got %h expected %h", got, expv);
            end
         end
      end
   endtask

   task automatic test_arrow();
      stim_t items[$];
      bit have;
      logic [EXP_W-1:0] got, expv;
      items.push_back(mk(20, 500, 1, 0, 0, 1));
      items.push_back(mk(0, 767));
      items.push_back(mk(0, 768));
      for (int v = 0; v <= 17; v++)
         for (int h = 0; h <= 17; h++) items.push_back(mk(h, v));
      items.push_back(mk(1023, 0));
      items.push_back(mk(0, 16));
      foreach (items[i]) begin
         drive_cycle(items[i], have, got, expv);
         if (have) begin
            n_cmp++;
            if (got !== expv) begin
               n_fail++;
               $display("FAIL arrow: got %h expected %h", got, expv);
            end
         end
      end
   endtask

   task automatic test_clipping();
      stim_t items[$];
      bit have;
      logic [EXP_W-1:0] got, expv;
      items.push_back(mk(3, 100, 1, 1020, 760, 3));
      items.push_back(mk(0, 767));
      items.push_back(mk(0, 768));
      items.push_back(mk(0, 790));
      for (int v = 758; v <= 767; v++) begin
         for (int h = 1016; h <= 1027; h++) items.push_back(mk(h, v));
         for (int h = 0; h <= 3; h++) items.push_back(mk(h, (v + 1) % V_VIS));
      end
      // Next frame: nothing wraps onto the top-left rows.
      items.push_back(mk(0, 768));
      items.push_back(mk(0, 769));
      for (int v = 0; v <= 2; v++) begin
         for (int h = 0; h <= 3; h++) items.push_back(mk(h, v));
         for (int h = 1016; h <= 1023; h++) items.push_back(mk(h, v));
      end
      foreach (items[i]) begin
         drive_cycle(items[i], have, got, expv);
         if (have) begin
            n_cmp++;
            if (got !== expv) begin
               n_fail++;
               $display("FAIL clipping: got %h expected %h", got, expv);
            end
         end
      end
   endtask

   task automatic test_blanking();
      stim_t items[$];
      bit have;
      logic [EXP_W-1:0] got, expv;
      int rows[3] = '{100, 107, 115};
      items.push_back(mk(3, 50, 1, 1016, 100, 3));
      items.push_back(mk(0, 767));
      items.push_back(mk(0, 768));
      foreach (rows[r])
         for (int h = 1014; h <= 1034; h++) items.push_back(mk(h, rows[r]));
      // Crosshair column sitting inside horizontal blank.
      items.push_back(mk(3, 300, 1, 1030, 100, 2));
      items.push_back(mk(0, 768));
      for (int h = 1020; h <= 1034; h++) items.push_back(mk(h, 100));
      for (int k = 0; k < 8; k++) items.push_back(mk(1030, rnd(0, V_TOT - 1)));
      foreach (items[i]) begin
         drive_cycle(items[i], have, got, expv);
         if (have) begin
            n_cmp++;
            if (got !== expv) begin
               n_fail++;
               $display("FAIL blanking: got %h expected %h", got, expv);
            end
         end
      end
   endtask

   task automatic test_random();
      stim_t s;
      bit have;
      logic [EXP_W-1:0] got, expv;
      int cx = 300, cy = 300;
      for (int i = 0; i < 1500; i++) begin
         s = mk(rnd(0, H_TOT - 1), rnd(0, V_TOT - 1));
         if (rnd(0, 1) == 1) begin
            s.h = cx + rnd(0, CUR_W + 1) - 1;
            s.v = cy + rnd(0, CUR_H + 1) - 1;
            if (s.h < 0 || s.h >= H_TOT) s.h = rnd(0, H_VIS - 1);
            if (s.v < 0 || s.v >= V_TOT) s.v = rnd(0, V_VIS - 1);
         end
         if (rnd(0, 15) == 0) begin
            s.pv = 1;
            s.x  = (rnd(0, 7) == 0) ? rnd(0, 4095) : rnd(0, 1100);
            s.y  = (rnd(0, 7) == 0) ? rnd(0, 4095) : rnd(0, 800);
            s.m  = rnd(0, 3);
            if (s.x < H_TOT && s.y < V_TOT) begin
               cx = s.x; cy = s.y;
            end
         end
         if (rnd(0, 199) == 0) s.rst = 1;
         drive_cycle(s, have, got, expv);
         if (have) begin
            n_cmp++;
            if (got !== expv) begin
               n_fail++;
               $display("FAIL random: got %h expected %h", got, expv);
            end
         end
      end
      // Flush the last two pixels through the pipeline.
      for (int i = 0; i < 2; i++) begin
         drive_cycle(mk(0, 0), have, got, expv);
         if (have) begin
            n_cmp++;
            if (got !== expv) begin
               n_fail++;
               $display("FAIL drain: got %h expected %h", got, expv);
            end
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst_lck = 1'b1; pos_valid = 1'b0; xpos = '0; ypos = '0; mode = '0;
      hcount_in = '0; vcount_in = '0; hsync_in = 1'b0; hblnk_in = 1'b0;
      vsync_in = 1'b0; vblnk_in = 1'b0; rgb_in = '0;
      test_reset();
      test_frame_sync();
      test_coincident();
      test_arrow();
      test_clipping();
      test_blanking();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
